// File: rtl/voice_playout_ctrl_if.sv
// rtl/voice_playout_ctrl_if.sv - Playout controller bus: LRCK, FIFO read side, DAC samples and status.
interface voice_playout_ctrl_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int LEVEL_WIDTH = 11,
  parameter int CNT_WIDTH   = 16
);
  logic                   enable;
  logic                   lrck;
  logic [DATA_WIDTH-1:0]  fifo_rd_data;
  logic                   fifo_empty;
  logic [LEVEL_WIDTH-1:0] fifo_level;
  logic                   fifo_rd_en;
  logic [DATA_WIDTH-1:0]  ldata;
  logic [DATA_WIDTH-1:0]  rdata;
  logic                   playing;
  logic [CNT_WIDTH-1:0]   underrun_cnt;
  logic [CNT_WIDTH-1:0]   drop_cnt;

  modport master (
    output enable, lrck, fifo_rd_data, fifo_empty, fifo_level,
    input  fifo_rd_en, ldata, rdata, playing, underrun_cnt, drop_cnt
  );

  modport slave (
    input  enable, lrck, fifo_rd_data, fifo_empty, fifo_level,
    output fifo_rd_en, ldata, rdata, playing, underrun_cnt, drop_cnt
  );
endinterface

// File: rtl/voice_playout_ctrl.sv
// rtl/voice_playout_ctrl.sv - Jitter-buffer playout: one FIFO read per LRCK frame, prefill, underrun, overfill trim.
// Optional VOICE_DECAY_EN: samples halve (sign-preserving) on underrun and PREFILL ticks instead of zeroing.
module voice_playout_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int LEVEL_WIDTH = 11,
  parameter int PREFILL_LVL = 256,
  parameter int HIGH_WATER  = 960,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk_12M,
  input  logic                  rst_n,
  voice_playout_ctrl_if.slave   bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PREFILL = 2'd1;
  localparam logic [1:0] S_PLAY    = 2'd2;

  localparam logic [LEVEL_WIDTH-1:0] L_PREFILL = LEVEL_WIDTH'(PREFILL_LVL);
  localparam logic [LEVEL_WIDTH-1:0] L_HIGH    = LEVEL_WIDTH'(HIGH_WATER);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);

  logic                  r_lrck_s1;
  logic                  r_lrck_s2;
  logic                  r_lrck_d;
  logic                  r_frame_tick;
  logic [1:0]            r_state;
  logic                  r_rd_en;
  logic                  r_rd_keep;
  logic                  r_second;
  logic                  r_rd_v;
  logic                  r_rd_keep_d;
  logic [DATA_WIDTH-1:0] r_sample;
  logic [CNT_WIDTH-1:0]  r_underrun_cnt;
  logic [CNT_WIDTH-1:0]  r_drop_cnt;
  logic                  w_rd_en;
  logic [DATA_WIDTH-1:0] w_fade;

`ifdef VOICE_DECAY_EN
  assign w_fade = {r_sample[DATA_WIDTH-1], r_sample[DATA_WIDTH-1:1]};
`else
  assign w_fade = '0;
`endif

  // Final guard so an empty FIFO is never strobed, whatever the sequencer asked for.
  assign w_rd_en = r_rd_en & ~bus.fifo_empty;

  always_ff @(posedge clk_12M or negedge rst_n) begin
    if (!rst_n) begin
      r_lrck_s1    <= 1'b0;
      r_lrck_s2    <= 1'b0;
      r_lrck_d     <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_lrck_s1    <= bus.lrck;
      r_lrck_s2    <= r_lrck_s1;
      r_lrck_d     <= r_lrck_s2;
      r_frame_tick <= r_lrck_d & ~r_lrck_s2;
    end
  end

  always_ff @(posedge clk_12M or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_rd_en        <= 1'b0;
      r_rd_keep      <= 1'b0;
      r_second       <= 1'b0;
      r_rd_v         <= 1'b0;
      r_rd_keep_d    <= 1'b0;
      r_sample       <= '0;
      r_underrun_cnt <= '0;
      r_drop_cnt     <= '0;
    end else begin
      r_rd_v      <= w_rd_en;
      r_rd_keep_d <= r_rd_keep;
      if (!bus.enable) begin
        // Dropping enable also kills any word still on its way back from the FIFO.
        r_state  <= S_IDLE;
        r_rd_en  <= 1'b0;
        r_second <= 1'b0;
        r_rd_v   <= 1'b0;
        r_sample <= '0;
      end else begin
        r_rd_en  <= 1'b0;
        r_second <= 1'b0;
        if (r_rd_v && r_rd_keep_d) begin
          r_sample <= bus.fifo_rd_data;
        end
        if (r_second) begin
          r_rd_en   <= 1'b1;
          r_rd_keep <= 1'b1;
        end
        case (r_state)
          S_IDLE: begin
            r_state <= S_PREFILL;
          end
          S_PREFILL: begin
            if (r_frame_tick) begin
              r_sample <= w_fade;
              if (bus.fifo_level >= L_PREFILL && !bus.fifo_empty) begin
                r_state   <= S_PLAY;
                r_rd_en   <= 1'b1;
                r_rd_keep <= 1'b1;
              end
            end
          end
          S_PLAY: begin
            if (r_frame_tick) begin
              if (bus.fifo_empty) begin
                r_sample <= w_fade;
                r_state  <= S_PREFILL;
                if (!(&r_underrun_cnt)) begin
                  r_underrun_cnt <= r_underrun_cnt + CNT_ONE;
                end
              end else if (bus.fifo_level > L_HIGH) begin
                // Overfill: burn the oldest word, play the next one.
                r_rd_en   <= 1'b1;
                r_rd_keep <= 1'b0;
                r_second  <= 1'b1;
                if (!(&r_drop_cnt)) begin
                  r_drop_cnt <= r_drop_cnt + CNT_ONE;
                end
              end else begin
                r_rd_en   <= 1'b1;
                r_rd_keep <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.fifo_rd_en   = w_rd_en;
  assign bus.ldata        = r_sample;
  assign bus.rdata        = r_sample;
  assign bus.playing      = (r_state == S_PLAY);
  assign bus.underrun_cnt = r_underrun_cnt;
  assign bus.drop_cnt     = r_drop_cnt;

endmodule

// File: doc/voice_playout_ctrl.md
Name: voice_playout_ctrl

Overview:
- Jitter-buffer playout controller between the UDP voice receive FIFO and the ES8156 I2S transmitter.
- Sequences FIFO reads at exactly one sample per LRCK frame once a prefill level is reached.
- Detects underrun and re-prefills; trims excess latency on overfill.
- Drives the DAC left/right sample word; replaces the free-running read enable at top level.

Parameters:
- DATA_WIDTH, 16, sample width.
- LEVEL_WIDTH, 11, width of FIFO fill-level input (FIFO depth 1024).
- PREFILL_LVL, 256, fill level required before entering or re-entering playback.
- HIGH_WATER, 960, fill level above which one extra sample is dropped per frame.

Ports:
- clk_12M  input  1  controller clock, 12.288 MHz.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  codec init done (adc_dac_init); low forces IDLE.
- lrck  input  1  DAC LRCK (es1_dlrc), asynchronous to clk_12M.
- fifo_rd_data  input  DATA_WIDTH  FIFO read data, valid 1 cycle after fifo_rd_en.
- fifo_empty  input  1  FIFO empty flag.
- fifo_level  input  LEVEL_WIDTH  FIFO fill level in words.
- fifo_rd_en  output  1  single-cycle FIFO read strobe.
- ldata  output  DATA_WIDTH  left sample to I2S TX.
- rdata  output  DATA_WIDTH  right sample to I2S TX (mono, equals ldata).
- playing  output  1  high in PLAY state.
- underrun_cnt  output  16  saturating underrun event counter.
- drop_cnt  output  16  saturating dropped-sample counter.

Behaviour:
- Reset values: fifo_rd_en=0, ldata=rdata=0, playing=0, underrun_cnt=0, drop_cnt=0, state=IDLE.
- lrck passes through a 2-FF synchronizer, then an edge register.
- frame_tick is a 1-cycle pulse on the synced lrck falling edge (start of the left channel).
- Latency: lrck edge to frame_tick is 3 clk_12M cycles.
- FSM IDLE: all outputs at reset values except the counters. enable=1 -> PREFILL.
- FSM PREFILL: no reads; ldata=0. At frame_tick with fifo_level>=PREFILL_LVL -> PLAY. The first read occurs at that same tick.
- FSM PLAY: each frame_tick issues fifo_rd_en for 1 cycle. Data is captured into ldata/rdata on the following cycle and held until the next capture.
- Overfill (PLAY): frame_tick with fifo_level>HIGH_WATER issues reads on two consecutive cycles.
  - The first word is discarded; the second word is captured.
  - drop_cnt increments by 1.
- Underrun (PLAY): frame_tick with fifo_empty=1 performs no read.
  - ldata=rdata=0, or decay if VOICE_DECAY_EN is defined.
  - underrun_cnt increments by 1; state -> PREFILL.
- fifo_rd_en is never asserted while fifo_empty=1.
- enable falls in any state: next cycle -> IDLE, fifo_rd_en=0, samples zeroed, playing=0. Any in-flight read word is discarded; counters are kept.
- A frame_tick cannot occur within 3 cycles of another (256 cycles/frame), so no tick overlaps a read sequence.
- Counters saturate at 16'hFFFF and clear only on rst_n.
- Mid-operation rst_n assertion: all state returns asynchronously to reset values.

Optional Feature:
- Macro: VOICE_DECAY_EN.
- Defined: on underrun and on every PREFILL frame_tick, ldata/rdata <= previous value arithmetic-shifted right by 1 (sign-preserving). The output decays toward 0/-1 instead of stepping to 0, which avoids clicks.
- Undefined: ldata/rdata are forced to 0 immediately on underrun and remain 0 throughout PREFILL.

Test Plan:
- Reset with enable=1, fifo_level=100, lrck toggling at 48 kHz -> stays PREFILL, fifo_rd_en never high, ldata=0.
- Level raised to 256, FIFO holds 16'h1234 then 16'h5678 -> PLAY at next tick; ldata=16'h1234 one cycle after the rd_en pulse, 16'h5678 one frame later; exactly one rd_en per frame.
- fifo_level=1000 at a tick with FIFO words A,B -> two consecutive rd_en pulses; ldata=B; drop_cnt=1.
- fifo_empty=1 at a tick while ldata=16'h4000 -> no rd_en, underrun_cnt=1, state PREFILL, playing=0.
  - Undefined macro: ldata=0.
  - VOICE_DECAY_EN defined: ldata=16'h2000, then 16'h1000 at the next tick.
- enable dropped the cycle after an rd_en pulse -> IDLE next cycle, ldata=0, returned word not captured, counters unchanged.
- Force 65,536 underruns -> underrun_cnt holds 16'hFFFF.
